// File: rtl/reaction_pkg.sv
// Shared types and widths for the reaction-time round controller.
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        WAIT_RAND,
        GO,
        DONE,
        FAULT
    } state_e;

    localparam int RES_W_DEF = 14;
    localparam int DELAY_W   = 16;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICKS_PER_MS cycles.
module ms_tick_gen #(
    parameter int TICKS_PER_MS = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICKS_PER_MS > 2) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICKS_PER_MS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == TERM);
        cnt_d = (clr || tick) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reaction_round_ctrl.sv
// One reaction-time round: seed from LFSR, random wait, GO, measure, report.
module reaction_round_ctrl
    import reaction_pkg::*;
#(
    parameter int TICKS_PER_MS   = 50000,
    parameter int MIN_DELAY_MS   = 1000,
    parameter int DELAY_SCALE_MS = 16,
    parameter int MAX_MS         = 9999,
    parameter int RES_W          = RES_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_btn,
    input  logic             react_btn,
    input  logic [7:0]       lfsr_out,
    input  logic             lfsr_cenable,
    output logic             lfsr_stop,
    output logic             led_go,
    output logic             busy,
    output logic [RES_W-1:0] result_ms,
    output logic             result_valid,
    output logic             timeout,
    output logic             false_start,
    output logic [RES_W-1:0] best_ms
);

    localparam logic [RES_W-1:0] MAX_L = RES_W'(MAX_MS);

    state_e state_q, state_d;

    logic               start_prev_q, react_prev_q;
    logic               start_edge, react_edge;
    logic               entering, tick;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [RES_W-1:0]   ms_cnt_q, ms_cnt_d, cnt_inc;
    logic [RES_W-1:0]   result_q, result_d;
    logic [RES_W-1:0]   best_q, best_d;
    logic               timeout_q, timeout_d;
    logic               fstart_q, fstart_d;
    logic               rv_q, rv_d;

    assign start_edge = start_btn & ~start_prev_q;
    assign react_edge = react_btn & ~react_prev_q;
    assign entering   = (state_d != state_q);
    assign cnt_inc    = ms_cnt_q + RES_W'(1);

    // Prescaler restarts on every state entry so each wait is whole ms.
    ms_tick_gen #(
        .TICKS_PER_MS(TICKS_PER_MS)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (entering),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_edge) state_d = SEED;
            end
            SEED: begin
                if (lfsr_cenable) state_d = WAIT_RAND;
            end
            WAIT_RAND: begin
                if (react_edge) begin
                    state_d = FAULT;
                end else if (tick && delay_q <= DELAY_W'(1)) begin
                    state_d = GO;
                end
            end
            GO: begin
                if (react_edge) begin
                    state_d = DONE;
                end else if (tick && cnt_inc >= MAX_L) begin
                    state_d = DONE;
                end
            end
            DONE, FAULT: begin
                if (start_edge) state_d = SEED;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lfsr_stop = (state_q == SEED);
        led_go    = (state_q == GO);
        busy      = (state_q == SEED) || (state_q == WAIT_RAND) ||
                    (state_q == GO);
    end

    always_comb begin
        delay_d   = delay_q;
        ms_cnt_d  = ms_cnt_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        fstart_d  = fstart_q;
        best_d    = best_q;
        if (entering && state_d == SEED) begin
            result_d  = '0;
            timeout_d = 1'b0;
            fstart_d  = 1'b0;
        end
        if (state_q == SEED && lfsr_cenable) begin
            delay_d = DELAY_W'(MIN_DELAY_MS +
                               int'(lfsr_out) * DELAY_SCALE_MS);
        end
        if (state_q == WAIT_RAND) begin
            if (react_edge) begin
                fstart_d = 1'b1;
            end else if (tick && delay_q != '0) begin
                delay_d = delay_q - DELAY_W'(1);
            end
        end
        if (state_q == GO) begin
            if (tick) ms_cnt_d = cnt_inc;
            // A press landing on a tick counts that tick, so MAX_MS is reachable.
            if (react_edge) begin
                result_d = tick ? cnt_inc : ms_cnt_q;
            end else if (tick && cnt_inc >= MAX_L) begin
                result_d  = MAX_L;
                timeout_d = 1'b1;
            end
        end
        if (entering && state_d == GO) ms_cnt_d = '0;
        rv_d = entering && (state_d == DONE);
        if (rv_d && !timeout_d && result_d < best_q) best_d = result_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_prev_q <= 1'b0;
            react_prev_q <= 1'b0;
            delay_q      <= '0;
            ms_cnt_q     <= '0;
            result_q     <= '0;
            timeout_q    <= 1'b0;
            fstart_q     <= 1'b0;
            best_q       <= '1;
            rv_q         <= 1'b0;
        end else begin
            start_prev_q <= start_btn;
            react_prev_q <= react_btn;
            delay_q      <= delay_d;
            ms_cnt_q     <= ms_cnt_d;
            result_q     <= result_d;
            timeout_q    <= timeout_d;
            fstart_q     <= fstart_d;
            best_q       <= best_d;
            rv_q         <= rv_d;
        end
    end

    assign result_ms    = result_q;
    assign result_valid = rv_q;
    assign timeout      = timeout_q;
    assign false_start  = fstart_q;
    assign best_ms      = best_q;

endmodule
